led_matrix_scanner: RTL and testbench

Parametrised multiplexed scanner for the diode bar array: holds a ROWS×COLS frame buffer, sequences one-hot row drive with column sinks, and applies per-row PWM brightness with daylight dimming and inter-row blanking. It sits between the display logic, which writes row bitmaps, and the top-level pad tri-state mapping onto the D (row) and G (column) pins.

---
 rtl/led_matrix_scanner.sv | 172 +++++++++++++++++
 tb/tb_led_matrix_scanner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// Multiplexed LED row/column scanner with per-row PWM, night dimming and inter-row blanking.
// Define LED_MATRIX_DOUBLE_BUFFER_EN for separate front/back frame buffers with commit/swap.
module led_matrix_scanner #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 10,
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned DIV_BITS = 16,
    parameter int unsigned RB       = $clog2(ROWS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIV_BITS-1:0] tick_div,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                daylight,
    input  logic                wr_en,
    input  logic [RB-1:0]       wr_row,
    input  logic [COLS-1:0]     wr_data,
    input  logic                commit,
    output logic [ROWS-1:0]     row_en,
    output logic [COLS-1:0]     col_sink,
    output logic                frame_start,
    output logic                commit_busy
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                night_q, night_d;
    logic [DIV_BITS-1:0] div_q;
    logic [DIV_BITS-1:0] div_limit;
    logic                tick;
    logic                frame_end;
    logic [PWM_BITS-1:0] eff;
    logic [COLS-1:0]     front_row;
    logic [ROWS-1:0]     row_en_d;
    logic [COLS-1:0]     col_sink_d;
    logic                frame_start_d;
    logic                wr_ok;
    logic [RW-1:0]       wr_idx;

    assign wr_ok  = wr_en && (32'(wr_row) < ROWS);
    assign wr_idx = RW'(wr_row);

    // Prescaler: a counter at or past the terminal value ticks and wraps, so a shrinking tick_div recovers in one cycle
    assign div_limit = (tick_div == '0) ? '0 : tick_div - DIV_BITS'(1);
    assign tick      = (div_q >= div_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + DIV_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BLANK;
            row_q       <= '0;
            pwm_q       <= '0;
            night_q     <= 1'b0;
            row_en      <= '0;
            col_sink    <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            pwm_q       <= pwm_d;
            night_q     <= night_d;
            row_en      <= row_en_d;
            col_sink    <= col_sink_d;
            frame_start <= frame_start_d;
        end
    end

    // Next state plus the output values registered alongside it
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        pwm_d         = pwm_q;
        night_d       = night_q;
        frame_end     = 1'b0;
        frame_start_d = 1'b0;
        row_en_d      = '0;
        col_sink_d    = '0;
        eff           = '0;

        if (tick) begin
            unique case (state_q)
                BLANK: begin
                    state_d       = DRIVE;
                    pwm_d         = '0;
                    night_d       = ~daylight;
                    frame_start_d = (row_q == '0);
                end
                DRIVE: begin
                    if (pwm_q == PWM_MAX) begin
                        state_d   = BLANK;
                        frame_end = (row_q == LAST_ROW);
                        row_d     = frame_end ? '0 : row_q + RW'(1);
                    end else begin
                        pwm_d = pwm_q + PWM_BITS'(1);
                    end
                end
            endcase
        end

        eff = night_d ? (brightness >> 2) : brightness;
        if (state_d == DRIVE) begin
            for (int i = 0; i < ROWS; i++) begin
                row_en_d[i] = (row_d == RW'(i));
            end
            col_sink_d = front_row & {COLS{pwm_d < eff}};
        end
    end

`ifdef LED_MATRIX_DOUBLE_BUFFER_EN
    logic [COLS-1:0] buf_q [2][ROWS];
    logic            sel_q;
    logic            pending_q;

    assign front_row   = buf_q[sel_q][row_d];
    assign commit_busy = pending_q;

    // Writes always land in the buffer that is not displayed; the swap just flips the pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                buf_q[0][r] <= '0;
                buf_q[1][r] <= '0;
            end
            sel_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                buf_q[~sel_q][wr_idx] <= wr_data;
            end
            if (frame_end && pending_q) begin
                sel_q <= ~sel_q;
            end
            pending_q <= pending_q ? ~frame_end : commit;
        end
    end
`else
    logic [COLS-1:0] buf_q [ROWS];
    logic            unused_commit;

    assign front_row     = buf_q[row_d];
    assign commit_busy   = 1'b0;
    assign unused_commit = commit ^ frame_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                buf_q[r] <= '0;
            end
        end else if (wr_ok) begin
            buf_q[wr_idx] <= wr_data;
        end
    end
`endif

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner: frame-position model plus directed literal checks.
// Follows LED_MATRIX_DOUBLE_BUFFER_EN to choose single- or double-buffer expectations.
module tb_led_matrix_scanner;

    localparam int unsigned ROWS     = 4;
    localparam int unsigned COLS     = 10;
    localparam int unsigned PWM_BITS = 4;
    localparam int unsigned DIV_BITS = 16;
    localparam int unsigned RB       = 3;
    localparam int PH = (1 << PWM_BITS) + 1;
    localparam int FR = ROWS * PH;
`ifdef LED_MATRIX_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic [DIV_BITS-1:0] tick_div;
    logic [PWM_BITS-1:0] brightness;
    logic                daylight;
    logic                wr_en;
    logic [RB-1:0]       wr_row;
    logic [COLS-1:0]     wr_data;
    logic                commit;
    logic [ROWS-1:0]     row_en;
    logic [COLS-1:0]     col_sink;
    logic                frame_start;
    logic                commit_busy;

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .PWM_BITS(PWM_BITS), .DIV_BITS(DIV_BITS), .RB(RB)
    ) dut (
        .clk(clk), .reset(reset), .tick_div(tick_div), .brightness(brightness),
        .daylight(daylight), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .commit(commit), .row_en(row_en), .col_sink(col_sink),
        .frame_start(frame_start), .commit_busy(commit_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_printed = 0;

    always @(posedge clk) cyc++;

    // Model: the display position is just the tick count modulo the frame length
    int              m_div;
    int              m_k;
    bit              m_night;
    bit              m_pending;
    bit              model_live = 1'b0;
    logic [COLS-1:0] m_front [ROWS];
    logic [COLS-1:0] m_back  [ROWS];
    logic [ROWS-1:0] e_row_en;
    logic [COLS-1:0] e_col;
    logic            e_fs;
    logic            e_busy;

    always @(posedge clk) begin : model
        int lim, row, ph, eff, idx;
        bit tk, swap_now;
        logic [COLS-1:0] tmp;
        model_live = 1'b1;
        if (reset) begin
            m_div = 0; m_k = 0; m_night = 1'b0; m_pending = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                m_front[r] = '0;
                m_back[r]  = '0;
            end
            e_row_en = '0; e_col = '0; e_fs = 1'b0; e_busy = 1'b0;
        end else begin
            lim      = (tick_div == '0) ? 1 : int'(tick_div);
            tk       = (m_div + 1 >= lim);
            m_div    = tk ? 0 : m_div + 1;
            e_fs     = 1'b0;
            swap_now = 1'b0;
            if (tk) begin
                m_k = (m_k + 1) % FR;
                if (m_k % PH == 1) begin
                    m_night = !daylight;
                    e_fs    = (m_k == 1);
                end
                swap_now = (m_k == 0) && m_pending;
            end
            row = m_k / PH;
            ph  = m_k % PH;
            eff = m_night ? int'(brightness) / 4 : int'(brightness);
            e_row_en = '0;
            e_col    = '0;
            if (ph != 0) begin
                e_row_en[row] = 1'b1;
                e_col = (ph - 1 < eff) ? m_front[row] : '0;
            end
            idx = int'(wr_row);
            if (wr_en && idx < ROWS) begin
                if (DB) m_back[idx] = wr_data;
                else    m_front[idx] = wr_data;
            end
            if (swap_now) begin
                for (int r = 0; r < ROWS; r++) begin
                    tmp        = m_front[r];
                    m_front[r] = m_back[r];
                    m_back[r]  = tmp;
                end
                m_pending = 1'b0;
            end else if (!m_pending) begin
                m_pending = DB && commit;
            end
            e_busy = m_pending;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (model_live) begin
            n_cmp++;
            if (row_en !== e_row_en || col_sink !== e_col || frame_start !== e_fs || commit_busy !== e_busy) begin
                n_bad++;
                if (n_printed < 20) begin
                    n_printed++;
                    $display("FAIL cycle_model @%0d: got row_en=%b col=%h fs=%b busy=%b, want row_en=%b col=%h fs=%b busy=%b",
                             cyc, row_en, col_sink, frame_start, commit_busy, e_row_en, e_col, e_fs, e_busy);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_fs(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < bound);
        if (frame_start !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_start_timeout: got no pulse within %0d cycles", bound);
        end
    endtask

    // Tallies over one whole frame at tick_div=1, starting on a frame_start cycle
    task automatic count_frame(output int r2_on, output int r2_full, output int blank,
                               output int r0_lit, output int lit);
        r2_on = 0; r2_full = 0; blank = 0; r0_lit = 0; lit = 0;
        for (int i = 0; i < FR; i++) begin
            if (row_en == 4'b0100) r2_on++;
            if (row_en == 4'b0100 && col_sink == 10'h3FF) r2_full++;
            if (row_en == 4'b0000 && col_sink == 10'h000) blank++;
            if (row_en == 4'b0001 && col_sink != 10'h000) r0_lit++;
            if (col_sink != 10'h000) lit++;
            @(negedge clk);
        end
    endtask

    initial begin
        int r2_on, r2_full, blank, r0_lit, lit, t0;
        reset = 1'b1; tick_div = 16'd1; brightness = 4'd15; daylight = 1'b1;
        wr_en = 1'b0; wr_row = '0; wr_data = '0; commit = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_row_en", 32'(row_en), 32'h0);
        check("reset_col_sink", 32'(col_sink), 32'h0);
        check("reset_busy", 32'(commit_busy), 32'h0);

        // Full brightness, row 2 all on
        reset = 1'b0; wr_en = 1'b1; wr_row = 3'd2; wr_data = 10'h3FF; commit = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; commit = 1'b0;
        wait_fs(200);
        count_frame(r2_on, r2_full, blank, r0_lit, lit);
        check("day_row2_drive_ticks", 32'(r2_on), 32'd16);
        check("day_row2_lit_ticks", 32'(r2_full), 32'd15);
        check("blank_ticks_per_frame", 32'(blank), 32'd4);

        // Night dimming: 4>>2 = 1 lit tick, 3>>2 = 0
        brightness = 4'd4; daylight = 1'b0;
        wait_fs(200);
        count_frame(r2_on, r2_full, blank, r0_lit, lit);
        check("night_b4_lit_ticks", 32'(lit), 32'd1);
        brightness = 4'd3;
        wait_fs(200);
        count_frame(r2_on, r2_full, blank, r0_lit, lit);
        check("night_b3_lit_ticks", 32'(lit), 32'd0);

        // Uncommitted write to row 0, then commit in the middle of row 1
        brightness = 4'd15; daylight = 1'b1;
        wr_en = 1'b1; wr_row = 3'd0; wr_data = 10'h155;
        @(negedge clk);
        wr_en = 1'b0;
        wait_fs(200);
        count_frame(r2_on, r2_full, blank, r0_lit, lit);
        check("uncommitted_row0_lit", 32'(r0_lit), DB ? 32'd0 : 32'd15);
        wait_fs(200);
        repeat (25) @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        check("busy_after_commit", 32'(commit_busy), DB ? 32'd1 : 32'd0);
        wait_fs(200);
        check("swap_row0_en", 32'(row_en), 32'h1);
        check("swap_row0_col", 32'(col_sink), 32'h155);
        check("swap_busy_clear", 32'(commit_busy), 32'h0);

        // Out-of-range row write is dropped; a second commit while pending is absorbed
        wr_en = 1'b1; wr_row = 3'd7; wr_data = 10'h3FF;
        @(negedge clk);
        wr_en = 1'b0; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        repeat (3) @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        check("busy_double_commit", 32'(commit_busy), DB ? 32'd1 : 32'd0);
        wait_fs(200);
        check("single_swap_row0_col", 32'(col_sink), DB ? 32'h0 : 32'h155);

        // Prescaler: 4 rows x 17 steps x 5 clk
        tick_div = 16'd5;
        wait_fs(400);
        t0 = cyc;
        @(negedge clk);
        check("frame_start_one_cycle", 32'(frame_start), 32'h0);
        wait_fs(400);
        check("frame_period_div5", 32'(cyc - t0), 32'd340);
        repeat (13) @(negedge clk);
        tick_div = 16'd2;
        repeat (50) @(negedge clk);
        tick_div = 16'd0;
        repeat (30) @(negedge clk);
        tick_div = 16'd1;

        // Reset in the middle of row 2 drive with a commit pending
        wait_fs(400);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        repeat (37) @(negedge clk);
        check("pre_reset_row2", 32'(row_en), 32'h4);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_row_en", 32'(row_en), 32'h0);
        check("midreset_col_sink", 32'(col_sink), 32'h0);
        check("midreset_busy", 32'(commit_busy), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_row0", 32'(row_en), 32'h1);
        check("post_reset_fs", 32'(frame_start), 32'h1);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
